// File: rtl/apb_protocol_checker_if.sv
// APB bus bundle observed by apb_protocol_checker; the monitor modport is purely passive.
interface apb_protocol_checker_if #(
  parameter int AW   = 8,
  parameter int DW   = 32,
  parameter int NSLV = 4
) ();
  logic [NSLV-1:0] PSEL;
  logic            PEN;
  logic            PWR;
  logic [AW-1:0]   ADDR;
  logic [DW-1:0]   PWDAT;
  logic [DW-1:0]   PRDAT;
  logic            PRDY;

  modport master  (output PSEL, PEN, PWR, ADDR, PWDAT, input  PRDAT, PRDY);
  modport slave   (input  PSEL, PEN, PWR, ADDR, PWDAT, output PRDAT, PRDY);
  modport monitor (input  PSEL, PEN, PWR, ADDR, PWDAT, PRDAT, PRDY);
endinterface

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker: follows IDLE/SETUP/ACCESS from the sampled bus,
// reports the lowest-coded violation per cycle and counts completed transfers.
module apb_protocol_checker #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic                   PCLK,
  input  logic                   PRST,
  apb_protocol_checker_if.monitor bus,
  input  logic                   clr,
  output logic                   viol_valid,
  output logic [2:0]             viol_code,
  output logic [5:0]             viol_sticky,
  output logic [CW-1:0]          wr_count,
  output logic [CW-1:0]          rd_count,
  output logic                   busy
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]   W_ONE    = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0]   TO_VAL   = WW'(TIMEOUT);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};
  localparam logic [NSLV-1:0] SEL_ONE  = {{(NSLV-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [NSLV-1:0] sel_cap_r;
  logic [AW-1:0]   addr_cap_r;
  logic            wr_cap_r;
  logic [DW-1:0]   wdat_cap_r;
  logic [WW-1:0]   wait_r, wait_s, wait_inc_s;
  logic            capture_s, done_s;
  logic            any_sel_s, multi_sel_s, match_s;
  logic [5:0]      fired_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [2:0] lowest_code(input logic [5:0] f);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (f[i]) c = 3'(i + 1);
      else      c = c;
    end
    return c;
  endfunction

  assign any_sel_s   = |bus.PSEL;
  assign multi_sel_s = (bus.PSEL & (bus.PSEL - SEL_ONE)) != '0;
  assign wait_inc_s  = wait_r + W_ONE;
  assign match_s     = (bus.PSEL == sel_cap_r) && (bus.ADDR == addr_cap_r) &&
                       (bus.PWR == wr_cap_r) && (!wr_cap_r || (bus.PWDAT == wdat_cap_r));

  // Next-state and violation detection; fired_s bit n-1 means code n was seen this edge.
  always_comb begin
    state_s   = state_r;
    wait_s    = wait_r;
    capture_s = 1'b0;
    done_s    = 1'b0;
    fired_s   = 6'b000000;
    case (state_r)
      IDLE: begin
        if (any_sel_s && bus.PEN) begin
          fired_s[1] = 1'b1;
        end else if (any_sel_s) begin
          state_s   = SETUP;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (!bus.PEN) begin
          fired_s[2] = 1'b1;
          if (any_sel_s) begin
            state_s   = SETUP;
            capture_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else if (match_s) begin
          state_s = ACCESS;
          wait_s  = '0;
        end else begin
          fired_s[3] = 1'b1;
          state_s    = IDLE;
        end
      end
      ACCESS: begin
        if (!any_sel_s || !bus.PEN) begin
          fired_s[5] = 1'b1;
          state_s    = IDLE;
        end else if (bus.PRDY) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          wait_s     = wait_inc_s;
          fired_s[4] = (wait_inc_s == TO_VAL);
          fired_s[3] = !match_s;
          if (fired_s[4] || fired_s[3]) state_s = IDLE;
          else                          state_s = ACCESS;
        end
      end
      default: state_s = IDLE;
    endcase
    // A multi-select abandons whatever the base rules decided for this edge.
    if (multi_sel_s) begin
      fired_s[0] = 1'b1;
      state_s    = IDLE;
      capture_s  = 1'b0;
      done_s     = 1'b0;
    end else begin
      fired_s[0] = 1'b0;
    end
  end

  // State, capture, registered reporting and saturating counters.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_r     <= IDLE;
      wait_r      <= '0;
      sel_cap_r   <= '0;
      addr_cap_r  <= '0;
      wr_cap_r    <= 1'b0;
      wdat_cap_r  <= '0;
      viol_valid  <= 1'b0;
      viol_code   <= 3'd0;
      viol_sticky <= 6'b000000;
      wr_count    <= '0;
      rd_count    <= '0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_r      <= wait_s;
      busy        <= (state_s != IDLE);
      viol_valid  <= |fired_s;
      viol_code   <= lowest_code(fired_s);
      viol_sticky <= (clr ? 6'b000000 : viol_sticky) | fired_s;
      if (capture_s) begin
        sel_cap_r  <= bus.PSEL;
        addr_cap_r <= bus.ADDR;
        wr_cap_r   <= bus.PWR;
        wdat_cap_r <= bus.PWDAT;
      end
      if (done_s && wr_cap_r) wr_count <= clr ? CNT_ONE : sat_inc(wr_count);
      else if (clr)           wr_count <= '0;
      if (done_s && !wr_cap_r) rd_count <= clr ? CNT_ONE : sat_inc(rd_count);
      else if (clr)            rd_count <= '0;
    end
  end
endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed and randomized bench for apb_protocol_checker against a rule-level reference model.
module tb_apb_protocol_checker;
  localparam int AW = 8, DW = 32, NSLV = 4, TIMEOUT = 16, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic PCLK = 1'b0;
  logic PRST = 1'b1;
  logic clr  = 1'b0;
  logic viol_valid, busy;
  logic [2:0] viol_code;
  logic [5:0] viol_sticky;
  logic [CW-1:0] wr_count, rd_count;
  int checks = 0;
  int errors = 0;

  apb_protocol_checker_if #(.AW(AW), .DW(DW), .NSLV(NSLV)) bus ();

  apb_protocol_checker #(.AW(AW), .DW(DW), .NSLV(NSLV), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .PCLK(PCLK), .PRST(PRST), .bus(bus), .clr(clr),
    .viol_valid(viol_valid), .viol_code(viol_code), .viol_sticky(viol_sticky),
    .wr_count(wr_count), .rd_count(rd_count), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: an open transfer (active), whether its enable phase began, and its waits.
  bit m_active, m_enabled;
  int m_waits;
  logic [NSLV-1:0] m_sel;
  logic [AW-1:0] m_addr;
  logic m_wr;
  logic [DW-1:0] m_wdat;
  int m_wrc, m_rdc, m_code;
  bit [5:0] m_sticky;
  bit m_valid;

  task automatic model_step();
    bit [5:0] fired;
    bit multi, any, same, in_setup, in_access, completed, start, begin_access;
    if (PRST) begin
      m_active = 0; m_enabled = 0; m_waits = 0; m_wrc = 0; m_rdc = 0;
      m_sticky = '0; m_valid = 0; m_code = 0;
      return;
    end
    fired = '0;
    multi = $countones(bus.PSEL) > 1;
    any = bus.PSEL != '0;
    same = bus.PSEL == m_sel && bus.ADDR == m_addr && bus.PWR == m_wr &&
           (!m_wr || bus.PWDAT == m_wdat);
    in_setup = m_active && !m_enabled;
    in_access = m_active && m_enabled;
    if (!m_active && any && bus.PEN) fired[1] = 1;
    if (in_setup && !bus.PEN) fired[2] = 1;
    if (in_setup && bus.PEN && !same) fired[3] = 1;
    if (in_access && any && bus.PEN && !bus.PRDY && !same) fired[3] = 1;
    if (in_access && any && bus.PEN && !bus.PRDY && m_waits + 1 == TIMEOUT) fired[4] = 1;
    if (in_access && (!any || !bus.PEN)) fired[5] = 1;
    if (multi) fired[0] = 1;
    completed = in_access && any && bus.PEN && bus.PRDY && !multi;
    start = any && !bus.PEN && !multi && (!m_active || in_setup);
    begin_access = in_setup && bus.PEN && same && !multi;

    if (clr) begin m_wrc = 0; m_rdc = 0; m_sticky = '0; end
    if (completed && m_wr) m_wrc = (m_wrc < CMAX) ? m_wrc + 1 : CMAX;
    if (completed && !m_wr) m_rdc = (m_rdc < CMAX) ? m_rdc + 1 : CMAX;
    m_sticky |= fired;
    m_valid = fired != '0;
    m_code = 0;
    for (int i = 5; i >= 0; i--) if (fired[i]) m_code = i + 1;

    if (begin_access) begin
      m_enabled = 1; m_waits = 0;
    end else if (start) begin
      m_active = 1; m_enabled = 0;
      m_sel = bus.PSEL; m_addr = bus.ADDR; m_wr = bus.PWR; m_wdat = bus.PWDAT;
    end else if (in_access && fired == '0 && !completed) begin
      m_waits++;
    end else begin
      m_active = 0; m_enabled = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge PCLK);
    model_step();
    #1;
    chk("viol_valid", {31'd0, viol_valid}, {31'd0, m_valid});
    chk("viol_code", {29'd0, viol_code}, 32'(m_code));
    chk("viol_sticky", {26'd0, viol_sticky}, {26'd0, m_sticky});
    chk("wr_count", 32'(wr_count), 32'(m_wrc));
    chk("rd_count", 32'(rd_count), 32'(m_rdc));
    chk("busy", {31'd0, busy}, {31'd0, m_active});
  endtask

  task automatic drive(input logic [NSLV-1:0] s, input logic p, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rdy, input logic c, input logic r);
    bus.PSEL = s; bus.PEN = p; bus.PWR = w; bus.ADDR = a; bus.PWDAT = d;
    bus.PRDY = rdy; bus.PRDAT = $urandom; clr = c; PRST = r;
    cyc();
  endtask

  initial begin
    logic [3:0] s;
    logic p, w, rd, c, r;
    logic [7:0] a;
    logic [31:0] d;
    int k;
    bus.PSEL = '0; bus.PEN = 1'b0; bus.PWR = 1'b0; bus.ADDR = '0;
    bus.PWDAT = '0; bus.PRDAT = '0; bus.PRDY = 1'b0;

    drive(4'b0000, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sticky", {26'd0, viol_sticky}, 32'd0);
    drive(4'b0000, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);

    // Write with two wait states.
    drive(4'b0001, 1'b0, 1'b1, 8'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    chk("wr_setup_busy", {31'd0, busy}, 32'd1);
    drive(4'b0001, 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b1, 8'h10, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0);
    chk("wr_done_count", 32'(wr_count), 32'd1);
    chk("wr_done_sticky", {26'd0, viol_sticky}, 32'd0);
    drive(4'b0000, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);

    // Multi-select.
    drive(4'b0011, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("multi_valid", {31'd0, viol_valid}, 32'd1);
    chk("multi_code", {29'd0, viol_code}, 32'd1);
    chk("multi_sticky", {26'd0, viol_sticky}, 32'h01);
    drive(4'b0000, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("pulse_one_cycle", {31'd0, viol_valid}, 32'd0);

    // Read timeout.
    drive(4'b0010, 1'b0, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(4'b0010, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      drive(4'b0010, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0);
      if (i == TIMEOUT) begin
        chk("timeout_code", {29'd0, viol_code}, 32'd5);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_rd_count", 32'(rd_count), 32'd0);
      end else begin
        chk("timeout_early", {31'd0, viol_valid}, 32'd0);
      end
    end

    // Address change during wait together with a multi-select.
    drive(4'b0000, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
    drive(4'b0001, 1'b0, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(4'b0110, 1'b1, 1'b0, 8'h14, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("unstable_multi_code", {29'd0, viol_code}, 32'd1);
    chk("unstable_multi_sticky", {26'd0, viol_sticky}, 32'h09);

    // Read counter saturation, then clear coinciding with a completion.
    drive(4'b0000, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= CMAX + 1; i++) begin
      drive(4'b0100, 1'b0, 1'b0, 8'(i), 32'h0, 1'b0, 1'b0, 1'b0);
      drive(4'b0100, 1'b1, 1'b0, 8'(i), 32'h0, 1'b0, 1'b0, 1'b0);
      drive(4'b0100, 1'b1, 1'b0, 8'(i), 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("rd_saturate", 32'(rd_count), 32'(CMAX));
    drive(4'b0100, 1'b0, 1'b0, 8'h33, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(4'b0100, 1'b1, 1'b0, 8'h33, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(4'b0100, 1'b1, 1'b0, 8'h33, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("clr_with_done", 32'(rd_count), 32'd1);

    // Reset in the middle of an access.
    drive(4'b1000, 1'b0, 1'b1, 8'h44, 32'h12345678, 1'b0, 1'b0, 1'b0);
    drive(4'b1000, 1'b1, 1'b1, 8'h44, 32'h12345678, 1'b0, 1'b0, 1'b0);
    drive(4'b0011, 1'b1, 1'b1, 8'h44, 32'h12345678, 1'b1, 1'b0, 1'b1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, viol_valid}, 32'd0);
    chk("rst_rd", 32'(rd_count), 32'd0);
    chk("rst_wr", 32'(wr_count), 32'd0);
    chk("rst_sticky", {26'd0, viol_sticky}, 32'd0);

    // Mostly well-formed random traffic with occasional disturbances.
    for (int n = 0; n < 3000; n++) begin
      k = int'($urandom_range(0, 99));
      s = bus.PSEL; a = bus.ADDR; w = bus.PWR; d = bus.PWDAT;
      if (!m_active) begin
        if (k < 55)      s = 4'b0001 << $urandom_range(0, 3);
        else if (k < 62) s = 4'($urandom_range(0, 15));
        else             s = 4'b0000;
        p = ($urandom_range(0, 9) == 0);
        w = 1'($urandom_range(0, 1));
        a = 8'($urandom_range(0, 3));
        d = 32'($urandom_range(0, 3));
      end else begin
        p = (k < 92);
        if (k >= 97) a = 8'($urandom_range(0, 3));
        if (k == 96) s = 4'($urandom_range(0, 15));
        if (k == 95) d = 32'($urandom_range(0, 3));
        if (k == 94) w = ~w;
      end
      rd = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 249) == 0);
      drive(s, p, w, a, d, rd, c, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
